// File: rtl/pattern_sequencer_pkg.sv
// Shared constants for the VGA test-pattern sequencer: debouncer state encodings,
// raster origin, pattern indices and reset colour.
package pattern_sequencer_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } db_state_t;

  localparam logic [2:0] COLOR_RESET = 3'b111;

  localparam logic [9:0] H_ORIGIN = '0;
  localparam logic [9:0] V_ORIGIN = '0;

  localparam logic [1:0] PAT_BLOCK = 2'd0;
  localparam logic [1:0] PAT_CROSS = 2'd1;
  localparam logic [1:0] PAT_BOX   = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  // Colour 0 (black) is never selected: 7 wraps straight to 1.
  function automatic logic [2:0] next_color(input logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

endpackage

// File: rtl/pattern_sequencer_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, four-state debounce FSM and a
// one-cycle press pulse on each accepted low-to-high transition.
module btn_debounce
  import pattern_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  db_state_t     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      st_q    <= STABLE_LO;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // The cycle that leaves a STABLE state already counts as the first differing
  // sample, so the press pulse lands 2 + DEBOUNCE_CYCLES cycles after the raw edge.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (st_q)
      STABLE_LO: begin
        if (sync2_q) begin
          st_d  = CHECK_HI;
          cnt_d = CW'(1);
        end
      end
      CHECK_HI: begin
        if (!sync2_q) begin
          st_d  = STABLE_LO;
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          st_d    = STABLE_HI;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!sync2_q) begin
          st_d  = CHECK_LO;
          cnt_d = CW'(1);
        end
      end
      CHECK_LO: begin
        if (sync2_q) begin
          st_d  = STABLE_HI;
          cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
          st_d  = STABLE_LO;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        st_d  = STABLE_LO;
        cnt_d = '0;
      end
    endcase
  end

  assign press_o = press_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Test-pattern sequencer: queues pattern/colour advances from buttons or the
// auto-cycle timer and applies them only at the frame boundary.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned AUTO_FRAMES     = 120,
  parameter int unsigned NUM_PATTERNS    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_color,
  input  logic       auto_en,
  input  logic [9:0] hcnt,
  input  logic [9:0] vcnt,
  output logic [1:0] state,
  output logic [2:0] color,
  output logic       frame_tick,
  output logic       pending
);

  localparam int unsigned FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_FRAMES - 1);
  localparam logic [1:0]    PAT_LAST   = 2'(NUM_PATTERNS - 1);

  logic          press_next, press_color;
  logic          at_origin, auto_req, next_set;
  logic          origin_q, tick_q;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          next_pend_q, next_pend_d;
  logic          col_pend_q, col_pend_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    color_q, color_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_next),
    .press_o(press_next)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_color (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_color),
    .press_o(press_color)
  );

  always_comb begin
    at_origin = (hcnt == H_ORIGIN) && (vcnt == V_ORIGIN);
    auto_req  = auto_en && tick_q && (fcnt_q == FRAME_LAST);
    next_set  = press_next || auto_req;

    if (!auto_en || press_next) begin
      fcnt_d = '0;
    end else if (tick_q) begin
      fcnt_d = (fcnt_q == FRAME_LAST) ? '0 : fcnt_q + FW'(1);
    end else begin
      fcnt_d = fcnt_q;
    end

    state_d     = state_q;
    color_d     = color_q;
    next_pend_d = next_pend_q | next_set;
    col_pend_d  = col_pend_q | press_color;

    // A request arriving on the tick cycle survives into the next frame.
    if (tick_q) begin
      if (next_pend_q) begin
        state_d = (state_q == PAT_LAST) ? PAT_BLOCK : state_q + 2'd1;
      end
      if (col_pend_q) begin
        color_d = next_color(color_q);
      end
      next_pend_d = next_set;
      col_pend_d  = press_color;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      origin_q    <= 1'b0;
      tick_q      <= 1'b0;
      fcnt_q      <= '0;
      next_pend_q <= 1'b0;
      col_pend_q  <= 1'b0;
      state_q     <= PAT_BLOCK;
      color_q     <= COLOR_RESET;
    end else begin
      origin_q    <= at_origin;
      tick_q      <= at_origin && !origin_q;
      fcnt_q      <= fcnt_d;
      next_pend_q <= next_pend_d;
      col_pend_q  <= col_pend_d;
      state_q     <= state_d;
      color_q     <= color_d;
    end
  end

  assign state      = state_q;
  assign color      = color_q;
  assign frame_tick = tick_q;
  assign pending    = next_pend_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer on a 16x8 mini raster (128 cycles/frame).
module tb_pattern_sequencer;
  import pattern_sequencer_pkg::*;

  logic       clk;
  logic       rst;
  logic       btn_next;
  logic       btn_color;
  logic       auto_en;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [1:0] state;
  logic [2:0] color;
  logic       frame_tick;
  logic       pending;

  int checks;
  int errors;
  int pos;
  bit hold;

  pattern_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_FRAMES    (3),
    .NUM_PATTERNS   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_next  (btn_next),
    .btn_color (btn_color),
    .auto_en   (auto_en),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .state     (state),
    .color     (color),
    .frame_tick(frame_tick),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_raster();
    hcnt = 10'(pos % 16);
    vcnt = 10'(pos / 16);
  endtask

  // One clock: sample point is #1 after the edge, then the raster moves on.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!hold) pos = (pos + 1) % 128;
    set_raster();
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    tick();
    while (frame_tick !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("frame_tick_wait", 32'(frame_tick), 32'd1);
  endtask

  task automatic goto_pos(input int p);
    int n;
    n = 0;
    while (pos != p && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $error("FAIL goto_pos: observed %0d expected %0d", pos, p);
    end
  endtask

  task automatic press(input int sel);
    if (sel == 0) btn_next = 1'b1; else btn_color = 1'b1;
    repeat (10) tick();
    btn_next  = 1'b0;
    btn_color = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    logic [1:0] exp_seq [3];
    logic [1:0] exp_auto_s [12];
    logic       exp_auto_p [12];

    exp_seq    = '{2'd2, 2'd3, 2'd0};
    exp_auto_s = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    exp_auto_p = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    checks    = 0;
    errors    = 0;
    hold      = 1'b0;
    rst       = 1'b1;
    btn_next  = 1'b0;
    btn_color = 1'b0;
    auto_en   = 1'b0;
    pos       = 100;
    set_raster();

    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_color", 32'(color), 32'd7);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Bounce: 1-cycle toggles never survive the debounce window.
    wait_tick();
    btn_next = 1'b1; tick();
    btn_next = 1'b0; tick();
    btn_next = 1'b1; tick();
    btn_next = 1'b0; tick();
    repeat (10) tick();
    chk("bounce_pending", 32'(pending), 32'd0);
    wait_tick();
    tick();
    chk("bounce_state", 32'(state), 32'd0);

    // Clean press: pulse 6 cycles after raw edge, pending visible one cycle later.
    btn_next = 1'b1;
    repeat (6) tick();
    chk("press_pend_early", 32'(pending), 32'd0);
    tick();
    chk("press_pend_set", 32'(pending), 32'd1);
    repeat (3) tick();
    btn_next = 1'b0;
    repeat (8) tick();
    chk("press_midframe_state", 32'(state), 32'd0);
    wait_tick();
    chk("press_tick_cycle_state", 32'(state), 32'd0);
    tick();
    chk("press_applied_state", 32'(state), 32'd1);
    chk("press_pend_clear", 32'(pending), 32'd0);

    for (int i = 0; i < 3; i++) begin
      press(0);
      wait_tick();
      tick();
      chk("seq_state", 32'(state), 32'(exp_seq[i]));
    end

    // Two presses in one frame give a single advance.
    press(0);
    press(0);
    chk("dbl_pending", 32'(pending), 32'd1);
    chk("dbl_mid_state", 32'(state), 32'd0);
    wait_tick();
    tick();
    chk("dbl_state", 32'(state), 32'd1);
    wait_tick();
    tick();
    chk("dbl_no_second", 32'(state), 32'd1);

    // Raster parked at origin: one pulse only.
    goto_pos(0);
    hold = 1'b1;
    tick();
    chk("hold_tick_first", 32'(frame_tick), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_tick_again", 32'(frame_tick), 32'd0);
    end
    hold = 1'b0;

    // Auto mode: advance every 3 frames.
    auto_en = 1'b1;
    for (int f = 0; f < 12; f++) begin
      wait_tick();
      tick();
      chk("auto_state", 32'(state), 32'(exp_auto_s[f]));
      chk("auto_pending", 32'(pending), 32'(exp_auto_p[f]));
    end
    wait_tick();
    tick();
    chk("auto_t12_state", 32'(state), 32'd1);
    press(0);
    wait_tick();
    tick();
    chk("auto_manual_state", 32'(state), 32'd2);
    wait_tick();
    tick();
    chk("auto_restart_t14_pend", 32'(pending), 32'd0);
    wait_tick();
    tick();
    chk("auto_restart_t15_state", 32'(state), 32'd2);
    chk("auto_restart_t15_pend", 32'(pending), 32'd1);
    wait_tick();
    tick();
    chk("auto_restart_t16_state", 32'(state), 32'd3);
    auto_en = 1'b0;

    // Colour advances, 7 wraps to 1.
    press(1);
    chk("col_mid", 32'(color), 32'd7);
    wait_tick();
    chk("col_tick_cycle", 32'(color), 32'd7);
    tick();
    chk("col_wrap", 32'(color), 32'd1);
    press(1);
    wait_tick();
    tick();
    chk("col_next", 32'(color), 32'd2);

    // Press pulse lands on the frame_tick cycle: deferred one frame.
    goto_pos(123);
    btn_next = 1'b1;
    repeat (6) tick();
    chk("coin_align_tick", 32'(frame_tick), 32'd1);
    chk("coin_pend_before", 32'(pending), 32'd0);
    tick();
    chk("coin_pend_kept", 32'(pending), 32'd1);
    chk("coin_state_held", 32'(state), 32'd3);
    btn_next = 1'b0;
    wait_tick();
    tick();
    chk("coin_state_wrap", 32'(state), 32'd0);
    chk("coin_pend_clear", 32'(pending), 32'd0);

    // Asynchronous reset mid-frame with state=2 and an advance queued.
    press(0);
    wait_tick();
    tick();
    press(0);
    wait_tick();
    tick();
    chk("pre_rst_state", 32'(state), 32'd2);
    press(0);
    chk("pre_rst_pending", 32'(pending), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_color", 32'(color), 32'd7);
    chk("async_rst_pending", 32'(pending), 32'd0);
    chk("async_rst_tick", 32'(frame_tick), 32'd0);
    tick();
    rst = 1'b0;
    wait_tick();
    tick();
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_color", 32'(color), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
